fm_write_back_arb: RTL and testbench
====================================

FM_WRITE_BACK_ARB -- requirements
Module: fm_write_back_arb

Interface
REQ-001 SHALL have parameter NUM_ROW, default 4, number of PE rows feeding write-back.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, >=2), per-row FIFO entries for each of the fm and guard paths.
REQ-003 SHALL have parameter FM_AW, default 10, fm buffer address width.
REQ-004 SHALL have parameter GD_AW, default 8, guard buffer address width.
REQ-005 SHALL have port clk, input, 1, clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1, one-cycle layer start pulse.
REQ-008 SHALL have ports fm_base, input, FM_AW, and gd_base, input, GD_AW, which are the first write addresses, sampled on start.
REQ-009 SHALL have port fm_data, input, 8*NUM_ROW, per-row output activation byte.
REQ-010 SHALL have port fm_valid, input, NUM_ROW, per-row valid for fm_data.
REQ-011 SHALL have port fm_last, input, NUM_ROW, marking the row's final fm beat of the layer; it qualifies with fm_valid.
REQ-012 SHALL have port fm_ready, output, NUM_ROW, per-row ready (the fm_buf_ready of the PE rows).
REQ-013 SHALL have ports gd_data, input, 6*NUM_ROW, gd_valid, input, NUM_ROW, and gd_ready, output, NUM_ROW, forming the per-row guard handshake.
REQ-014 SHALL have ports wb_fm_wr_en, output, 1; wb_fm_wr_addr, output, FM_AW; and wb_fm_din, output, 8, forming the fm buffer write port.
REQ-015 SHALL have ports wb_gd_wr_en, output, 1; wb_gd_wr_addr, output, GD_AW; and wb_gd_din, output, 6, forming the guard buffer write port.
REQ-016 SHALL have port row_finish, output, NUM_ROW, a one-cycle pulse per row (the write_back_finish of the PE rows).
REQ-017 SHALL have port layer_done, output, 1, a one-cycle layer-complete pulse.
REQ-018 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-019 SHALL have port wrap_err, output, 1, a sticky address-wrap error flag.

Function
REQ-020 SHALL run the FSM states IDLE, RUN, DRAIN and DONE; start in IDLE moves to RUN and loads fm_ptr=fm_base and gd_ptr=gd_base.
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL go from RUN to DRAIN when every row has had an accepted fm beat with fm_last=1; the last flag SHALL be set in the same cycle it is accepted.
REQ-023 SHALL go from DRAIN to DONE when all fm and guard FIFOs are empty and no write is issued that cycle; DONE SHALL last one cycle, assert layer_done and return to IDLE.
REQ-024 SHALL accept a push (fm_valid & fm_ready) into the row's fm FIFO; fm_ready = state in {RUN} & row FIFO not full & row last-flag clear.
REQ-025 SHALL set gd_ready = state in {RUN, DRAIN} & row guard FIFO not full; a push SHALL occur on gd_valid & gd_ready.
REQ-026 SHALL hold ready low when a FIFO is full, even if the FIFO pops in the same cycle (no pass-through).
REQ-027 SHALL have a round-robin arbiter per path that picks one non-empty row FIFO per cycle, starting from the row after the last grant; the pointer SHALL be row 0 after reset and on start.
REQ-028 SHALL, on a grant, drive wb_*_wr_en=1 in the next cycle (one-cycle registered latency) with din = FIFO head and addr = ptr, then increment ptr.
REQ-029 SHALL increment pointers modulo 2^FM_AW and 2^GD_AW respectively.
REQ-030 SHALL run the fm and guard paths independently; both SHALL be able to write in the same cycle.
REQ-031 SHALL pulse row_finish[r] for one cycle when row r's last-flag is set, its fm and guard FIFOs are empty and its final beat has been written; it SHALL pulse once per layer per row.
REQ-032 SHALL, when all rows finish in the same cycle, pulse all row_finish bits together.

Reset
REQ-033 SHALL, on asynchronous rst_n=0, enter IDLE with FIFOs empty, pointers 0, arbiters at row 0, last-flags cleared, and all outputs 0 (including fm_ready, gd_ready and wrap_err).
REQ-034 SHALL, on reset mid-layer, discard in-flight data; no write SHALL issue until the next start.

Configuration
REQ-035 SHALL, with WB_WRAP_CHECK_EN defined, set wrap_err sticky when either pointer wraps from all-ones to 0 during a layer; it SHALL clear only on rst_n or on start.
REQ-036 SHALL, without WB_WRAP_CHECK_EN, tie wrap_err to 0 and remove the check logic.

Verification
REQ-037 SHALL cover: NUM_ROW=4, fm_base=16, each row sends 3 beats (last on the 3rd) -> 12 fm writes at addresses 16..27 in round-robin row order 0,1,2,3, then 4 row_finish pulses and layer_done, then busy=0.
REQ-038 SHALL cover: row 2 fm_valid held high while wb writes are blocked by other rows' traffic -> its FIFO fills to 4, fm_ready[2]=0, no beat lost and order preserved.
REQ-039 SHALL cover: gd_base=255, GD_AW=8, 2 guard beats -> addresses 255 then 0; wrap_err=1 with macro, 0 without.
REQ-040 SHALL cover: start pulsed during RUN -> ignored, pointers unchanged.
REQ-041 SHALL cover: rst_n asserted after 5 writes in RUN -> all outputs 0 immediately; a new start with fm_base=0 writes from address 0.
REQ-042 SHALL cover: all rows assert fm_last in the same cycle with 1-beat layers -> 4 writes, simultaneous row_finish=4'b1111, layer_done one cycle later.

Source files
------------

// File: rtl/fm_write_back_arb.sv
// fm_write_back_arb -- collects per-row output activations (fm) and guard
// bytes from NUM_ROW PE rows into small per-row FIFOs, then round-robin
// arbitrates each path onto a single buffer write port with
// auto-incrementing addresses.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 layer start pulse (honoured only in IDLE)
//   fm_base, gd_base      first write addresses, sampled on start
//   fm_data/valid/last    per-row fm beats; fm_ready back to the rows
//   gd_data/valid         per-row guard beats; gd_ready back to the rows
//   wb_fm_*               fm buffer write port (registered)
//   wb_gd_*               guard buffer write port (registered)
//   row_finish            one-cycle per-row completion pulse
//   layer_done            one-cycle layer completion pulse
//   busy                  high whenever the FSM is not in IDLE
//   wrap_err              sticky address-wrap flag
//
// Build option: define WB_WRAP_CHECK_EN to enable the address-wrap check;
// without it wrap_err is tied low.
module fm_write_back_arb #(
  parameter int NUM_ROW    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int FM_AW      = 10,
  parameter int GD_AW      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [FM_AW-1:0]     fm_base,
  input  logic [GD_AW-1:0]     gd_base,
  input  logic [8*NUM_ROW-1:0] fm_data,
  input  logic [NUM_ROW-1:0]   fm_valid,
  input  logic [NUM_ROW-1:0]   fm_last,
  output logic [NUM_ROW-1:0]   fm_ready,
  input  logic [6*NUM_ROW-1:0] gd_data,
  input  logic [NUM_ROW-1:0]   gd_valid,
  output logic [NUM_ROW-1:0]   gd_ready,
  output logic                 wb_fm_wr_en,
  output logic [FM_AW-1:0]     wb_fm_wr_addr,
  output logic [7:0]           wb_fm_din,
  output logic                 wb_gd_wr_en,
  output logic [GD_AW-1:0]     wb_gd_wr_addr,
  output logic [5:0]           wb_gd_din,
  output logic [NUM_ROW-1:0]   row_finish,
  output logic                 layer_done,
  output logic                 busy,
  output logic                 wrap_err
);

  localparam int RW = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [NUM_ROW-1:0] last_q, fin_q;
  logic [RW-1:0]      fm_rr_q, gd_rr_q;
  logic [FM_AW-1:0]   fm_ptr_q;
  logic [GD_AW-1:0]   gd_ptr_q;
  logic               fm_wr_en_q, gd_wr_en_q;
  logic [FM_AW-1:0]   fm_addr_q;
  logic [GD_AW-1:0]   gd_addr_q;
  logic [7:0]         fm_din_q;
  logic [5:0]         gd_din_q;

  logic [NUM_ROW-1:0]   fm_push, fm_pop, fm_empty, fm_full;
  logic [NUM_ROW-1:0]   gd_push, gd_pop, gd_empty, gd_full;
  logic [8*NUM_ROW-1:0] fm_head;
  logic [6*NUM_ROW-1:0] gd_head;
  logic [RW:0]          fm_pick, gd_pick;
  logic                 fm_gnt_vld, gd_gnt_vld;
  logic [RW-1:0]        fm_gnt_row, gd_gnt_row;
  logic                 start_acc, active, port_idle;

  // Returns {found, row}: first requesting row at or after 'base', wrapping.
  function automatic logic [RW:0] rr_pick(input logic [NUM_ROW-1:0] req,
                                          input logic [RW-1:0] base);
    logic [RW:0] res;
    int          idx;
    res = '0;
    // Scan farthest offset first so the nearest requester overwrites it.
    for (int k = NUM_ROW - 1; k >= 0; k--) begin
      idx = int'(base) + k;
      if (idx >= NUM_ROW) idx -= NUM_ROW;
      if (req[idx]) res = {1'b1, RW'(idx)};
    end
    return res;
  endfunction

  function automatic logic [RW-1:0] next_row(input logic [RW-1:0] row);
    return (row == RW'(NUM_ROW - 1)) ? '0 : row + 1'b1;
  endfunction

  assign start_acc = start && (state_q == IDLE);
  assign active    = (state_q != IDLE);
  assign port_idle = !fm_wr_en_q && !gd_wr_en_q;

  assign fm_ready = {NUM_ROW{state_q == RUN}} & ~fm_full & ~last_q;
  assign gd_ready = {NUM_ROW{(state_q == RUN) || (state_q == DRAIN)}} & ~gd_full;
  assign fm_push  = fm_valid & fm_ready;
  assign gd_push  = gd_valid & gd_ready;

  assign fm_pick    = rr_pick(~fm_empty, fm_rr_q);
  assign gd_pick    = rr_pick(~gd_empty, gd_rr_q);
  assign fm_gnt_vld = active && fm_pick[RW];
  assign gd_gnt_vld = active && gd_pick[RW];
  assign fm_gnt_row = fm_pick[RW-1:0];
  assign gd_gnt_row = gd_pick[RW-1:0];
  assign fm_pop     = {NUM_ROW{fm_gnt_vld}} & (NUM_ROW'(1) << fm_gnt_row);
  assign gd_pop     = {NUM_ROW{gd_gnt_vld}} & (NUM_ROW'(1) << gd_gnt_row);

  // Row completion is reported only while both write ports are quiet, so a
  // row's final beat has left the output register, and rows that drain
  // together report in the same cycle.
  assign row_finish = {NUM_ROW{((state_q == RUN) || (state_q == DRAIN)) && port_idle}}
                      & last_q & fm_empty & gd_empty & ~fin_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ROW; gi++) begin : g_row
      logic [7:0] fm_mem_q [FIFO_DEPTH];
      logic [5:0] gd_mem_q [FIFO_DEPTH];
      logic [AW:0] fm_wr_q, fm_rd_q, gd_wr_q, gd_rd_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          fm_wr_q <= '0;
          fm_rd_q <= '0;
          gd_wr_q <= '0;
          gd_rd_q <= '0;
        end else begin
          if (fm_push[gi]) fm_wr_q <= fm_wr_q + 1'b1;
          if (fm_pop[gi])  fm_rd_q <= fm_rd_q + 1'b1;
          if (gd_push[gi]) gd_wr_q <= gd_wr_q + 1'b1;
          if (gd_pop[gi])  gd_rd_q <= gd_rd_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (fm_push[gi]) fm_mem_q[fm_wr_q[AW-1:0]] <= fm_data[gi*8 +: 8];
        if (gd_push[gi]) gd_mem_q[gd_wr_q[AW-1:0]] <= gd_data[gi*6 +: 6];
      end

      // Extra MSB on the pointers separates full from empty.
      assign fm_empty[gi] = (fm_wr_q == fm_rd_q);
      assign gd_empty[gi] = (gd_wr_q == gd_rd_q);
      assign fm_full[gi]  = (fm_wr_q[AW] != fm_rd_q[AW]) &&
                            (fm_wr_q[AW-1:0] == fm_rd_q[AW-1:0]);
      assign gd_full[gi]  = (gd_wr_q[AW] != gd_rd_q[AW]) &&
                            (gd_wr_q[AW-1:0] == gd_rd_q[AW-1:0]);
      assign fm_head[gi*8 +: 8] = fm_mem_q[fm_rd_q[AW-1:0]];
      assign gd_head[gi*6 +: 6] = gd_mem_q[gd_rd_q[AW-1:0]];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (&last_q) state_d = DRAIN;
      // A guard push landing this cycle would be stranded, so wait for it.
      DRAIN:   if ((&fm_empty) && (&gd_empty) && port_idle && !(|gd_push))
                 state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= '0;
      fin_q      <= '0;
      fm_rr_q    <= '0;
      gd_rr_q    <= '0;
      fm_ptr_q   <= '0;
      gd_ptr_q   <= '0;
      fm_wr_en_q <= 1'b0;
      gd_wr_en_q <= 1'b0;
      fm_addr_q  <= '0;
      gd_addr_q  <= '0;
      fm_din_q   <= '0;
      gd_din_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        fm_ptr_q <= fm_base;
        gd_ptr_q <= gd_base;
        fm_rr_q  <= '0;
        gd_rr_q  <= '0;
        last_q   <= '0;
        fin_q    <= '0;
      end else begin
        last_q <= last_q | (fm_push & fm_last);
        fin_q  <= fin_q | row_finish;
        if (fm_gnt_vld) begin
          fm_ptr_q <= fm_ptr_q + 1'b1;
          fm_rr_q  <= next_row(fm_gnt_row);
        end
        if (gd_gnt_vld) begin
          gd_ptr_q <= gd_ptr_q + 1'b1;
          gd_rr_q  <= next_row(gd_gnt_row);
        end
      end
      fm_wr_en_q <= fm_gnt_vld;
      gd_wr_en_q <= gd_gnt_vld;
      if (fm_gnt_vld) begin
        fm_addr_q <= fm_ptr_q;
        fm_din_q  <= fm_head[int'(fm_gnt_row)*8 +: 8];
      end
      if (gd_gnt_vld) begin
        gd_addr_q <= gd_ptr_q;
        gd_din_q  <= gd_head[int'(gd_gnt_row)*6 +: 6];
      end
    end
  end

`ifdef WB_WRAP_CHECK_EN
  logic wrap_q;
  // Grants only happen during a layer; a grant at all-ones wraps the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wrap_q <= 1'b0;
    else if (start_acc)
      wrap_q <= 1'b0;
    else if ((fm_gnt_vld && (&fm_ptr_q)) || (gd_gnt_vld && (&gd_ptr_q)))
      wrap_q <= 1'b1;
  end
  assign wrap_err = wrap_q;
`else
  assign wrap_err = 1'b0;
`endif

  assign wb_fm_wr_en   = fm_wr_en_q;
  assign wb_fm_wr_addr = fm_addr_q;
  assign wb_fm_din     = fm_din_q;
  assign wb_gd_wr_en   = gd_wr_en_q;
  assign wb_gd_wr_addr = gd_addr_q;
  assign wb_gd_din     = gd_din_q;
  assign layer_done    = (state_q == DONE);
  assign busy          = active;

endmodule

// File: tb/tb_fm_write_back_arb.sv
module tb_fm_write_back_arb;

  localparam logic WRAP_EXP =
`ifdef WB_WRAP_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  fm_base = '0;
  logic [7:0]  gd_base = '0;
  logic [31:0] fm_data = '0;
  logic [3:0]  fm_valid = '0, fm_last = '0, fm_ready;
  logic [23:0] gd_data = '0;
  logic [3:0]  gd_valid = '0, gd_ready;
  logic        wb_fm_wr_en, wb_gd_wr_en;
  logic [9:0]  wb_fm_wr_addr;
  logic [7:0]  wb_fm_din;
  logic [7:0]  wb_gd_wr_addr;
  logic [5:0]  wb_gd_din;
  logic [3:0]  row_finish;
  logic        layer_done, busy, wrap_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [9:0] fa_q[$];
  logic [7:0] fd_q[$];
  logic [7:0] ga_q[$];
  logic [5:0] gdd_q[$];
  logic [3:0] rf_val[$];
  int         rf_cyc[$];
  int         ld_cnt = 0;
  int         ld_cyc = 0;
  logic       saw_bp2 = 1'b0;

  fm_write_back_arb dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .fm_base(fm_base), .gd_base(gd_base),
    .fm_data(fm_data), .fm_valid(fm_valid), .fm_last(fm_last), .fm_ready(fm_ready),
    .gd_data(gd_data), .gd_valid(gd_valid), .gd_ready(gd_ready),
    .wb_fm_wr_en(wb_fm_wr_en), .wb_fm_wr_addr(wb_fm_wr_addr), .wb_fm_din(wb_fm_din),
    .wb_gd_wr_en(wb_gd_wr_en), .wb_gd_wr_addr(wb_gd_wr_addr), .wb_gd_din(wb_gd_din),
    .row_finish(row_finish), .layer_done(layer_done), .busy(busy), .wrap_err(wrap_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (wb_fm_wr_en) begin
      fa_q.push_back(wb_fm_wr_addr);
      fd_q.push_back(wb_fm_din);
    end
    if (wb_gd_wr_en) begin
      ga_q.push_back(wb_gd_wr_addr);
      gdd_q.push_back(wb_gd_din);
    end
    if (row_finish != 4'b0) begin
      rf_val.push_back(row_finish);
      rf_cyc.push_back(cyc);
    end
    if (layer_done) begin
      ld_cnt = ld_cnt + 1;
      ld_cyc = cyc;
    end
  end

  task automatic clear_mon();
    fa_q.delete(); fd_q.delete(); ga_q.delete(); gdd_q.delete();
    rf_val.delete(); rf_cyc.delete();
    ld_cnt = 0;
  endtask

  // Runs one layer: row r sends nfm[r*4+:4] fm beats (data r*16+beat, last on
  // the final one) and ngd[r*4+:4] guard beats. mid_start >= 0 pulses start
  // with different bases at that iteration of the drive loop.
  task automatic run_layer(input logic [9:0] fmb, input logic [7:0] gdb,
                           input logic [15:0] nfm, input logic [15:0] ngd,
                           input int mid_start, input string name);
    int fc[4];
    int gc[4];
    logic [3:0] acc_f, acc_g;
    bit all_sent;
    clear_mon();
    fc = '{default: 0};
    gc = '{default: 0};
    @(negedge clk);
    fm_base = fmb; gd_base = gdb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 300; t++) begin
      all_sent = 1'b1;
      for (int r = 0; r < 4; r++) begin
        if (fc[r] < int'(nfm[r*4 +: 4])) begin
          fm_valid[r] = 1'b1;
          fm_data[r*8 +: 8] = 8'(r*16 + fc[r]);
          fm_last[r] = (fc[r] == int'(nfm[r*4 +: 4]) - 1);
          all_sent = 1'b0;
        end else begin
          fm_valid[r] = 1'b0;
          fm_last[r] = 1'b0;
        end
        if (gc[r] < int'(ngd[r*4 +: 4])) begin
          gd_valid[r] = 1'b1;
          gd_data[r*6 +: 6] = 6'(r*16 + gc[r]);
          all_sent = 1'b0;
        end else begin
          gd_valid[r] = 1'b0;
        end
      end
      if (t == mid_start) begin
        start = 1'b1; fm_base = fmb + 10'd400; gd_base = gdb + 8'd1;
      end
      if (all_sent) break;
      acc_f = fm_valid & fm_ready;
      acc_g = gd_valid & gd_ready;
      if (busy && fm_valid[2] && !fm_ready[2]) saw_bp2 = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int r = 0; r < 4; r++) begin
        fc[r] += int'(acc_f[r]);
        gc[r] += int'(acc_g[r]);
      end
    end
    fm_valid = '0; fm_last = '0; gd_valid = '0; start = 1'b0;
    for (int t = 0; t < 100 && ld_cnt == 0; t++) @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ld_cnt != 1) begin
      failures++;
      $display("FAIL %s_layer_done: got %0d pulses, need 1", name, ld_cnt);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_after: got %b, need 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, wb_fm_wr_en, wb_gd_wr_en, fm_ready, gd_ready, row_finish, layer_done, wrap_err} !== 15'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b, need 0", {busy, wb_fm_wr_en, wb_gd_wr_en, fm_ready, gd_ready, row_finish, layer_done, wrap_err});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, fm_ready, gd_ready} !== 9'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got %b, need 0", {busy, fm_ready, gd_ready});
    end
    $display("test_reset done");
  endtask

  task automatic test_round_robin();
    int per_row[4];
    run_layer(10'd16, 8'd0, 16'h3333, 16'h0000, -1, "rr");
    checks++;
    if (fa_q.size() != 12) begin
      failures++;
      $display("FAIL rr_count: got %0d writes, need 12", fa_q.size());
    end
    for (int i = 0; i < 12 && i < fa_q.size(); i++) begin
      checks++;
      if (fa_q[i] !== 10'(16 + i) || fd_q[i] !== 8'((i % 4) * 16 + i / 4)) begin
        failures++;
        $display("FAIL rr_write%0d: got addr %0d data %h, need addr %0d data %h",
                 i, fa_q[i], fd_q[i], 16 + i, 8'((i % 4) * 16 + i / 4));
      end
    end
    per_row = '{default: 0};
    foreach (rf_val[k]) for (int r = 0; r < 4; r++) per_row[r] += int'(rf_val[k][r]);
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (per_row[r] != 1) begin
        failures++;
        $display("FAIL rr_row_finish%0d: got %0d pulses, need 1", r, per_row[r]);
      end
    end
    $display("test_round_robin: %0d fm writes, %0d finish events", fa_q.size(), rf_val.size());
  endtask

  task automatic test_backpressure();
    int nxt[4];
    int row, beat;
    saw_bp2 = 1'b0;
    run_layer(10'd500, 8'd0, 16'h8888, 16'h0000, -1, "bp");
    checks++;
    if (saw_bp2 !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready2_low: got %b, need 1", saw_bp2);
    end
    checks++;
    if (fa_q.size() != 32) begin
      failures++;
      $display("FAIL bp_count: got %0d writes, need 32", fa_q.size());
    end
    nxt = '{default: 0};
    for (int i = 0; i < fa_q.size(); i++) begin
      row = int'(fd_q[i][7:4]);
      beat = int'(fd_q[i][3:0]);
      checks++;
      if (row > 3 || beat != nxt[row] || fa_q[i] !== 10'(500 + i)) begin
        failures++;
        $display("FAIL bp_order%0d: got addr %0d row %0d beat %0d, need addr %0d next beat of row",
                 i, fa_q[i], row, beat, 500 + i);
      end
      if (row <= 3) nxt[row] = nxt[row] + 1;
    end
    checks++;
    if (nxt[2] != 8) begin
      failures++;
      $display("FAIL bp_row2_total: got %0d beats, need 8", nxt[2]);
    end
    $display("test_backpressure: %0d fm writes, row2 beats %0d", fa_q.size(), nxt[2]);
  endtask

  task automatic test_guard_wrap();
    run_layer(10'd300, 8'd255, 16'h1111, 16'h0002, -1, "wrap");
    checks++;
    if (ga_q.size() != 2) begin
      failures++;
      $display("FAIL wrap_gd_count: got %0d writes, need 2", ga_q.size());
    end else begin
      checks++;
      if (ga_q[0] !== 8'd255 || gdd_q[0] !== 6'd0 || ga_q[1] !== 8'd0 || gdd_q[1] !== 6'd1) begin
        failures++;
        $display("FAIL wrap_gd_addr: got %0d/%h %0d/%h, need 255/00 0/01",
                 ga_q[0], gdd_q[0], ga_q[1], gdd_q[1]);
      end
    end
    checks++;
    if (fa_q.size() != 4 || (fa_q.size() > 0 && fa_q[0] !== 10'd300)) begin
      failures++;
      $display("FAIL wrap_fm: got %0d writes, need 4 starting at 300", fa_q.size());
    end
    checks++;
    if (wrap_err !== WRAP_EXP) begin
      failures++;
      $display("FAIL wrap_err: got %b, need %b", wrap_err, WRAP_EXP);
    end
    $display("test_guard_wrap: gd writes %0d wrap_err %b", ga_q.size(), wrap_err);
  endtask

  task automatic test_start_ignored();
    run_layer(10'd100, 8'd10, 16'h2222, 16'h0000, 1, "ign");
    checks++;
    if (fa_q.size() != 8) begin
      failures++;
      $display("FAIL ign_count: got %0d writes, need 8", fa_q.size());
    end
    for (int i = 0; i < fa_q.size() && i < 8; i++) begin
      checks++;
      if (fa_q[i] !== 10'(100 + i)) begin
        failures++;
        $display("FAIL ign_addr%0d: got %0d, need %0d", i, fa_q[i], 100 + i);
      end
    end
    checks++;
    if (wrap_err !== 1'b0) begin
      failures++;
      $display("FAIL ign_wrap_cleared: got %b, need 0", wrap_err);
    end
    $display("test_start_ignored: %0d fm writes", fa_q.size());
  endtask

  task automatic test_reset_mid_layer();
    clear_mon();
    @(negedge clk);
    fm_base = 10'd40; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fm_valid = 4'b1111; fm_last = 4'b0000; fm_data = 32'h33221100;
    for (int t = 0; t < 50 && fa_q.size() < 5; t++) @(negedge clk);
    checks++;
    if (fa_q.size() < 5) begin
      failures++;
      $display("FAIL rst_mid_writes: got %0d writes, need 5", fa_q.size());
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, wb_fm_wr_en, wb_gd_wr_en, fm_ready, gd_ready, row_finish, layer_done, wrap_err,
         wb_fm_wr_addr, wb_fm_din} !== 33'b0) begin
      failures++;
      $display("FAIL rst_mid_outputs: got %b, need 0",
               {busy, wb_fm_wr_en, wb_gd_wr_en, fm_ready, gd_ready, row_finish, layer_done, wrap_err});
    end
    fm_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    repeat (6) @(negedge clk);
    checks++;
    if (fa_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_write: got %0d writes busy %b, need 0 and 0", fa_q.size(), busy);
    end
    run_layer(10'd0, 8'd0, 16'h1111, 16'h0000, -1, "rst");
    checks++;
    if (fa_q.size() != 4 || fa_q[0] !== 10'd0) begin
      failures++;
      $display("FAIL rst_restart_addr: got %0d writes first %0d, need 4 first 0",
               fa_q.size(), (fa_q.size() > 0) ? int'(fa_q[0]) : -1);
    end
    $display("test_reset_mid_layer: restart writes %0d", fa_q.size());
  endtask

  task automatic test_back_to_back();
    run_layer(10'd200, 8'd0, 16'h1111, 16'h0000, -1, "b2b");
    checks++;
    if (fa_q.size() != 4) begin
      failures++;
      $display("FAIL b2b_count: got %0d writes, need 4", fa_q.size());
    end
    checks++;
    if (rf_val.size() != 1 || rf_val[0] !== 4'b1111) begin
      failures++;
      $display("FAIL b2b_finish: got %0d events first %b, need 1 event 1111",
               rf_val.size(), (rf_val.size() > 0) ? rf_val[0] : 4'b0);
    end else begin
      checks++;
      if (ld_cyc != rf_cyc[0] + 1) begin
        failures++;
        $display("FAIL b2b_done_latency: got cycle %0d, need %0d", ld_cyc, rf_cyc[0] + 1);
      end
    end
    $display("test_back_to_back: %0d writes, finish events %0d", fa_q.size(), rf_val.size());
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_guard_wrap();
    test_start_ignored();
    test_reset_mid_layer();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
